// File: rtl/reg_slice_pkg.sv
// reg_slice_pkg: state encodings shared by reg_slice and later slices.
// The state encoding doubles as the occupancy count.
package reg_slice_pkg;

  localparam logic [1:0] RS_EMPTY = 2'd0;
  localparam logic [1:0] RS_ONE   = 2'd1;
  localparam logic [1:0] RS_FULL  = 2'd2;

  function automatic logic rs_xfer(input logic i_valid, input logic i_ready);
    return i_valid && i_ready;
  endfunction

endpackage

// File: rtl/reg_slice.sv
// reg_slice: two-entry valid/ready register slice (main + skid register).
// Ports: CLK, RST (sync, active-high), S_VALID/S_READY/S_DATA upstream,
//        M_VALID/M_READY/M_DATA downstream, COUNT occupancy 0..2.
import reg_slice_pkg::*;

module reg_slice #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [1:0]       COUNT
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_m_valid;
  logic             r_s_ready;

  logic             w_in;
  logic             w_out;
  logic [1:0]       w_state_nxt;
  logic             w_ld_main;
  logic             w_main_from_skid;
  logic             w_ld_skid;

  assign w_in  = rs_xfer(S_VALID, r_s_ready);
  assign w_out = rs_xfer(r_m_valid, M_READY);

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_main_from_skid = 1'b0;
    w_ld_skid        = 1'b0;
    case (r_state)
      RS_EMPTY: begin
        if (w_in) begin
          w_state_nxt = RS_ONE;
          w_ld_main   = 1'b1;
        end
      end
      RS_ONE: begin
        if (w_in && w_out) begin
          w_ld_main   = 1'b1;
        end else if (w_in) begin
          w_state_nxt = RS_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out) begin
          w_state_nxt = RS_EMPTY;
        end
      end
      RS_FULL: begin
        if (M_READY) begin
          w_state_nxt      = RS_ONE;
          w_ld_main        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RS_EMPTY;
      end
    endcase
  end

  // Handshake flags are registered copies decoded from the next state,
  // so neither output has a combinational path from S_VALID or M_READY.
  // S_READY is held low during reset and rises on the first free edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= RS_EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m_valid <= (w_state_nxt != RS_EMPTY);
      r_s_ready <= (w_state_nxt != RS_FULL);
      if (w_ld_main) begin
        r_main <= w_main_from_skid ? r_skid : S_DATA;
      end
      if (w_ld_skid) begin
        r_skid <= S_DATA;
      end
    end
  end

  assign S_READY = r_s_ready;
  assign M_VALID = r_m_valid;
  assign M_DATA  = r_main;
  assign COUNT   = r_state;

endmodule

// File: tb/tb_reg_slice.sv
// tb_reg_slice: queue-model bench for reg_slice, directed + random.
// Model: FIFO of accepted words, depth 2, ready low through reset.
module tb_reg_slice;

  localparam int W     = 4;
  localparam int CYCLE = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         m_ready = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   count;

  int total = 0;
  int bad   = 0;
  int q[$];
  bit mdl_rdy = 1'b0;
  bit armed   = 1'b0;

  always #(CYCLE/2) clk = ~clk;

  reg_slice #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RST    (rst),
    .S_VALID(s_valid),
    .S_READY(s_ready),
    .S_DATA (s_data),
    .M_VALID(m_valid),
    .M_READY(m_ready),
    .M_DATA (m_data),
    .COUNT  (count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(q.size()));
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(mdl_rdy));
    chk("m_data_known", 32'($isunknown(m_data)), 32'd0);
    if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
  endtask

  task automatic step(input bit r, input bit sv, input logic [W-1:0] sd,
                      input bit mr);
    bit acc;
    bit pop;
    @(negedge clk);
    rst     = r;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    if (armed) check_model();
    acc = !r && sv && mdl_rdy;
    pop = !r && mr && (q.size() != 0);
    @(posedge clk);
    #1;
    armed = 1'b1;
    if (r) begin
      q.delete();
      mdl_rdy = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(int'(sd));
      mdl_rdy = (q.size() < 2);
    end
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    step(0, 0, 0, 0);
    chk("rst_rel_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 4'(i), 1);
      chk("stream_data", 32'(m_data), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    step(0, 0, 0, 1);

    step(0, 1, 4'd3, 0);
    step(0, 1, 4'd4, 0);
    chk("stall_count", 32'(count), 32'd2);
    chk("stall_s_ready", 32'(s_ready), 32'd0);
    step(0, 1, 4'd5, 0);
    chk("stall_hold", 32'(m_data), 32'd3);
    step(0, 1, 4'd5, 1);
    chk("release_data", 32'(m_data), 32'd4);
    chk("release_s_ready", 32'(s_ready), 32'd1);
    step(0, 1, 4'd5, 1);
    chk("release_last", 32'(m_data), 32'd5);
    step(0, 0, 0, 1);

    step(0, 1, 4'd7, 0);
    step(0, 1, 4'd8, 1);
    chk("simul_data", 32'(m_data), 32'd8);
    chk("simul_count", 32'(count), 32'd1);
    step(0, 0, 0, 1);

    step(0, 1, 4'd9, 0);
    step(0, 1, 4'd10, 0);
    step(1, 0, 0, 0);
    chk("rfull_m_valid", 32'(m_valid), 32'd0);
    chk("rfull_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("rfull_gone", 32'(m_valid), 32'd0);
    end

    step(0, 1, 4'd1, 1);
    chk("bub_v0", 32'(m_valid), 32'd1);
    chk("bub_d0", 32'(m_data), 32'd1);
    step(0, 0, 0, 1);
    chk("bub_v1", 32'(m_valid), 32'd0);
    step(0, 1, 4'd2, 1);
    chk("bub_v2", 32'(m_valid), 32'd1);
    chk("bub_d2", 32'(m_data), 32'd2);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           4'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
